// File: rtl/ts_loss_window_ctrl.sv
// ts_loss_window_ctrl
// ---------------------------------------------------------------------------
// Measurement-window sequencer for the TS continuity/packet-loss error
// counter. It counts packet starts on the shared byte stream and closes a
// window every WINDOW_PKTS packets. At each close it snapshots the counter's
// error_count, pulses en_reset_counter to clear the counter, and offers a
// report through a one-entry valid/ready buffer. It also drives a threshold
// alarm and a stream-lost watchdog flag.
//
// Ports
//   clk              : single clock, rising edge
//   reset            : asynchronous, active-high reset
//   enable           : level, 1 = measuring
//   valid, sync      : byte-valid and packet-start marker of the TS stream
//   error_count[7:0] : counter's current error count
//   threshold[7:0]   : alarm threshold, 0 disables the alarm
//   en_reset_counter : registered one-cycle clear pulse to the counter
//   report_valid     : report buffer holds a report
//   report_ready     : consumer accepts the report when valid && ready
//   report_errors    : snapshotted error_count
//   report_pkts      : packets in the window (= WINDOW_PKTS)
//   report_seq       : window sequence number, wraps 255 -> 0
//   alarm            : last snapshot >= threshold (threshold != 0)
//   overrun          : sticky, a report was dropped because the buffer was full
//   stream_lost      : no packet start for TIMEOUT_CYC cycles while running
// ---------------------------------------------------------------------------
module ts_loss_window_ctrl #(
   parameter int WINDOW_PKTS = 1000,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        valid,
   input  logic        sync,
   input  logic [7:0]  error_count,
   input  logic [7:0]  threshold,
   output logic        en_reset_counter,
   output logic        report_valid,
   input  logic        report_ready,
   output logic [7:0]  report_errors,
   output logic [15:0] report_pkts,
   output logic [7:0]  report_seq,
   output logic        alarm,
   output logic        overrun,
   output logic        stream_lost
);

   localparam int              TO_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [15:0]     WIN    = 16'(WINDOW_PKTS);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t          state_reg,   state_next;
   logic [15:0]     pkt_cnt_reg, pkt_cnt_next;
   logic [TO_W-1:0] to_cnt_reg,  to_cnt_next;
   logic            lost_reg,    lost_next;
   logic            clr_reg,     clr_next;
   logic [7:0]      seq_reg,     seq_next;
   logic            alarm_reg,   alarm_next;
   logic            ovr_reg,     ovr_next;
   logic            rv_reg,      rv_next;
   logic [7:0]      rerr_reg,    rerr_next;
   logic [15:0]     rpkts_reg,   rpkts_next;
   logic [7:0]      rseq_reg,    rseq_next;

   logic            pkt_start;
   logic            close;

   assign pkt_start = valid && sync;

   // Next-state and next-output logic
   always_comb begin
      state_next   = state_reg;
      pkt_cnt_next = pkt_cnt_reg;
      to_cnt_next  = to_cnt_reg;
      lost_next    = lost_reg;
      clr_next     = 1'b0;
      seq_next     = seq_reg;
      alarm_next   = alarm_reg;
      ovr_next     = ovr_reg;
      rv_next      = rv_reg;
      rerr_next    = rerr_reg;
      rpkts_next   = rpkts_reg;
      rseq_next    = rseq_reg;
      close        = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            alarm_next   = 1'b0;
            pkt_cnt_next = '0;
            to_cnt_next  = '0;
            lost_next    = 1'b0;
            if (enable) begin
               state_next = ST_ARM;
               clr_next   = 1'b1;
            end
         end

         ST_ARM: begin
            pkt_cnt_next = '0;
            to_cnt_next  = '0;
            lost_next    = 1'b0;
            if (!enable) begin
               state_next = ST_IDLE;
               clr_next   = 1'b1;
               alarm_next = 1'b0;
            end else begin
               state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!enable) begin
               // Partial window is discarded; dropping enable beats a close.
               state_next   = ST_IDLE;
               clr_next     = 1'b1;
               alarm_next   = 1'b0;
               pkt_cnt_next = '0;
               to_cnt_next  = '0;
               lost_next    = 1'b0;
            end else if (pkt_start) begin
               to_cnt_next = '0;
               lost_next   = 1'b0;
               if (pkt_cnt_reg == WIN) begin
                  // Boundary packet becomes the counter's reference packet
                  // after the clear, so the count restarts at zero.
                  close        = 1'b1;
                  clr_next     = 1'b1;
                  pkt_cnt_next = '0;
               end else begin
                  pkt_cnt_next = pkt_cnt_reg + 16'd1;
               end
            end else begin
               if (to_cnt_reg != TO_MAX) begin
                  to_cnt_next = to_cnt_reg + TO_ONE;
               end
               lost_next = (to_cnt_next == TO_MAX);
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Report buffer: drain first so a close in the accept cycle can reload.
      if (rv_reg && report_ready) begin
         rv_next = 1'b0;
      end
      if (close) begin
         seq_next   = seq_reg + 8'd1;
         alarm_next = (threshold != 8'd0) && (error_count >= threshold);
         if (!rv_reg || report_ready) begin
            rv_next    = 1'b1;
            rerr_next  = error_count;
            rpkts_next = WIN;
            rseq_next  = seq_reg;
         end else begin
            ovr_next = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         pkt_cnt_reg <= '0;
         to_cnt_reg  <= '0;
         lost_reg    <= 1'b0;
         clr_reg     <= 1'b0;
         seq_reg     <= '0;
         alarm_reg   <= 1'b0;
         ovr_reg     <= 1'b0;
         rv_reg      <= 1'b0;
         rerr_reg    <= '0;
         rpkts_reg   <= '0;
         rseq_reg    <= '0;
      end else begin
         state_reg   <= state_next;
         pkt_cnt_reg <= pkt_cnt_next;
         to_cnt_reg  <= to_cnt_next;
         lost_reg    <= lost_next;
         clr_reg     <= clr_next;
         seq_reg     <= seq_next;
         alarm_reg   <= alarm_next;
         ovr_reg     <= ovr_next;
         rv_reg      <= rv_next;
         rerr_reg    <= rerr_next;
         rpkts_reg   <= rpkts_next;
         rseq_reg    <= rseq_next;
      end
   end

   assign en_reset_counter = clr_reg;
   assign report_valid     = rv_reg;
   assign report_errors    = rerr_reg;
   assign report_pkts      = rpkts_reg;
   assign report_seq       = rseq_reg;
   assign alarm            = alarm_reg;
   assign overrun          = ovr_reg;
   assign stream_lost      = lost_reg;

endmodule

// File: tb/tb_ts_loss_window_ctrl.sv
// Testbench for ts_loss_window_ctrl: directed scenarios followed by a
// randomized phase, all checked against an event-level reference model.
module tb_ts_loss_window_ctrl;

   localparam int W  = 4;
   localparam int TO = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        valid;
   logic        sync;
   logic [7:0]  error_count;
   logic [7:0]  threshold;
   logic        en_reset_counter;
   logic        report_valid;
   logic        report_ready;
   logic [7:0]  report_errors;
   logic [15:0] report_pkts;
   logic [7:0]  report_seq;
   logic        alarm;
   logic        overrun;
   logic        stream_lost;

   ts_loss_window_ctrl #(
      .WINDOW_PKTS(W),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .valid(valid),
      .sync(sync),
      .error_count(error_count),
      .threshold(threshold),
      .en_reset_counter(en_reset_counter),
      .report_valid(report_valid),
      .report_ready(report_ready),
      .report_errors(report_errors),
      .report_pkts(report_pkts),
      .report_seq(report_seq),
      .alarm(alarm),
      .overrun(overrun),
      .stream_lost(stream_lost)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model, tracked per clock edge in terms of events:
   // phase 0 = off, 1 = arming, 2 = measuring.
   typedef struct {
      int errors;
      int seq;
   } rep_t;

   rep_t m_q[$];
   int   m_phase;
   int   m_syncs;   // packet starts since the reference packet
   int   m_quiet;   // measuring cycles since the last packet start
   int   m_seq;
   bit   m_clr;
   bit   m_alarm;
   bit   m_overrun;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_phase   = 0;
      m_syncs   = 0;
      m_quiet   = 0;
      m_seq     = 0;
      m_clr     = 1'b0;
      m_alarm   = 1'b0;
      m_overrun = 1'b0;
   endtask

   // Predict the effect of the coming rising edge from the current inputs.
   task automatic model_edge();
      bit   ps;
      bit   close;
      rep_t r;
      ps    = valid && sync;
      close = 1'b0;
      m_clr = 1'b0;
      if (m_phase == 0) begin
         if (enable) begin
            m_phase = 1;
            m_clr   = 1'b1;
         end
      end else if (!enable) begin
         m_phase = 0;
         m_clr   = 1'b1;
         m_alarm = 1'b0;
      end else if (m_phase == 1) begin
         m_phase = 2;
         m_syncs = 0;
         m_quiet = 0;
      end else begin
         if (ps) begin
            m_quiet = 0;
            m_syncs++;
            if (m_syncs == W + 1) begin
               close   = 1'b1;
               m_syncs = 0;
            end
         end else begin
            m_quiet++;
         end
      end
      if (m_q.size() > 0 && report_ready) begin
         m_q.delete(0);
      end
      if (close) begin
         m_clr = 1'b1;
         if (m_q.size() == 0) begin
            r.errors = int'(error_count);
            r.seq    = m_seq;
            m_q.push_back(r);
         end else begin
            m_overrun = 1'b1;
         end
         m_seq   = (m_seq + 1) % 256;
         m_alarm = (threshold != 0) && (error_count >= threshold);
      end
   endtask

   task automatic check_all();
      chk("en_reset_counter", 32'(en_reset_counter), 32'(m_clr));
      chk("report_valid", 32'(report_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("report_errors", 32'(report_errors), m_q[0].errors);
         chk("report_pkts", 32'(report_pkts), W);
         chk("report_seq", 32'(report_seq), m_q[0].seq);
      end
      chk("alarm", 32'(alarm), 32'(m_alarm));
      chk("overrun", 32'(overrun), 32'(m_overrun));
      chk("stream_lost", 32'(stream_lost), 32'((m_phase == 2) && (m_quiet >= TO)));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic send_sync(input logic [7:0] errc);
      valid       = 1'b1;
      sync        = 1'b1;
      error_count = errc;
      tick();
      valid = 1'b0;
      sync  = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("rst_en_reset_counter", 32'(en_reset_counter), 0);
      chk("rst_report_valid", 32'(report_valid), 0);
      chk("rst_report_errors", 32'(report_errors), 0);
      chk("rst_report_pkts", 32'(report_pkts), 0);
      chk("rst_report_seq", 32'(report_seq), 0);
      chk("rst_alarm", 32'(alarm), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_stream_lost", 32'(stream_lost), 0);
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      enable       = 1'b0;
      valid        = 1'b0;
      sync         = 1'b0;
      error_count  = 8'd0;
      threshold    = 8'd0;
      report_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      tick();

      // 1: arm pulse, then first window closes on the 5th sync
      enable = 1'b1;
      tick();
      chk("t1_arm_pulse", 32'(en_reset_counter), 1);
      tick();
      chk("t1_arm_pulse_width", 32'(en_reset_counter), 0);
      for (int i = 0; i < 4; i++) send_sync(8'd1);
      chk("t1_no_early_report", 32'(report_valid), 0);
      send_sync(8'd3);
      chk("t1_report_valid", 32'(report_valid), 1);
      chk("t1_report_errors", 32'(report_errors), 3);
      chk("t1_report_pkts", 32'(report_pkts), 4);
      chk("t1_report_seq", 32'(report_seq), 0);
      chk("t1_close_pulse", 32'(en_reset_counter), 1);
      tick();

      // 2: second close while not ready is dropped, then drain
      for (int i = 0; i < 5; i++) send_sync(8'd7);
      chk("t2_overrun", 32'(overrun), 1);
      chk("t2_held_seq", 32'(report_seq), 0);
      chk("t2_held_errors", 32'(report_errors), 3);
      report_ready = 1'b1;
      tick();
      chk("t2_accepted", 32'(report_valid), 0);
      for (int i = 0; i < 5; i++) send_sync(8'd2);
      chk("t2_next_seq", 32'(report_seq), 2);

      // 3: threshold alarm
      threshold = 8'd5;
      for (int i = 0; i < 4; i++) send_sync(8'd0);
      send_sync(8'd5);
      chk("t3_alarm_eq", 32'(alarm), 1);
      for (int i = 0; i < 4; i++) send_sync(8'd0);
      send_sync(8'd4);
      chk("t3_alarm_below", 32'(alarm), 0);
      threshold = 8'd0;
      for (int i = 0; i < 4; i++) send_sync(8'd0);
      send_sync(8'd255);
      chk("t3_alarm_disabled", 32'(alarm), 0);

      // 4: enable drop coincides with the closing sync
      for (int i = 0; i < 4; i++) send_sync(8'd9);
      enable = 1'b0;
      send_sync(8'd9);
      chk("t4_clear_pulse", 32'(en_reset_counter), 1);
      chk("t4_no_report", 32'(report_valid), 0);
      tick();
      chk("t4_single_pulse", 32'(en_reset_counter), 0);

      // 5: stream_lost watchdog
      enable = 1'b1;
      tick();
      chk("t5_arm_pulse", 32'(en_reset_counter), 1);
      tick();
      for (int i = 1; i <= TO; i++) begin
         tick();
         if (i == TO - 1) chk("t5_not_lost_yet", 32'(stream_lost), 0);
      end
      chk("t5_lost", 32'(stream_lost), 1);
      send_sync(8'd0);
      chk("t5_lost_cleared", 32'(stream_lost), 0);
      // seq continues from 6 after the discarded window
      for (int i = 0; i < 5; i++) send_sync(8'd1);
      chk("t4_seq_unchanged", 32'(report_seq), 6);

      // 6: asynchronous reset with a pending report mid-window
      report_ready = 1'b0;
      for (int i = 0; i < 7; i++) send_sync(8'd4);
      chk("t6_pending", 32'(report_valid), 1);
      do_reset();
      tick();
      chk("t6_arm_pulse", 32'(en_reset_counter), 1);

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         enable       = ($urandom_range(0, 99) < 97);
         valid        = ($urandom_range(0, 1) == 1);
         sync         = ($urandom_range(0, 3) == 0);
         report_ready = ($urandom_range(0, 1) == 1);
         error_count  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0)
            threshold = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         tick();
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
